// File: rtl/system_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : system_key_ctrl
// Brief   : Push-button debounce, sticky press capture and maskable level IRQ
//           behind an Avalon-MM slave. Define SYSTEM_KEY_CTRL_SYNC_EN to add
//           a two-flop input synchroniser ahead of the debounce filters.
// Revision: 1.0
// ============================================================================
module system_key_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] w_key_s;

`ifdef SYSTEM_KEY_CTRL_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Resets to released so leaving reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    assign w_key_s = sync2_q;
`else
    assign w_key_s = in_port;
`endif

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      readdata_d, readdata_q;
    logic             irq_q;

    always_comb begin
        deb_d = deb_q;
        for (int k = 0; k < WIDTH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (w_key_s[k] == deb_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == c_CNT_MAX) begin
                deb_d[k] = w_key_s[k];
                cnt_d[k] = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    assign w_press = deb_q & ~deb_d;
    assign w_wr    = chipselect & ~write_n;
    assign w_clr   = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A press landing in the same cycle as its clear keeps the bit set.
    always_comb begin
        mask_d = (w_wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
        cap_d  = (cap_q & ~w_clr) | w_press;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = deb_q;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = cap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q      <= '1;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int k = 0; k < WIDTH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            deb_q      <= deb_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
            irq_q      <= |(cap_q & mask_q);
            for (int k = 0; k < WIDTH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

    generate
        if (WIDTH < 32) begin : g_wdata_unused
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_system_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_system_key_ctrl
// Brief   : Self-checking bench for system_key_ctrl (WIDTH=4, DEBOUNCE=4).
// Revision: 1.0
// ============================================================================
module tb_system_key_ctrl;

    localparam int DEB = 4;
`ifdef SYSTEM_KEY_CTRL_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int L = DEB + SYNC;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_port;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    system_key_ctrl #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_port(in_port),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        logic [3:0] keys;
        logic [3:0] mask;
        logic [3:0] exp_cap;
        logic       exp_irq;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            chk(e.name, readdata, e.exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        address = a;
        sb.push_back('{name, exp});
        step();
        pop_cmp();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        vecs[0] = '{4'hE, 4'h1, 4'h1, 1'b1};
        vecs[1] = '{4'h5, 4'h2, 4'hA, 1'b1};
        vecs[2] = '{4'hD, 4'h4, 4'h2, 1'b0};
        vecs[3] = '{4'h0, 4'hF, 4'hF, 1'b1};
        vecs[4] = '{4'hB, 4'h4, 4'h4, 1'b1};
        vecs[5] = '{4'h7, 4'h7, 4'h8, 1'b0};

        reset = 1'b1; in_port = 4'hF; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        idle(3);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;

        // Reset state via the register map
        rd(2'd0, 32'h0000000F, "rst_data");
        rd(2'd1, 32'h0, "rst_reserved");
        rd(2'd2, 32'h0, "rst_mask");
        rd(2'd3, 32'h0, "rst_cap");
        chk("rst_irq", {31'b0, irq}, 32'h0);

        // Glitch one cycle too short to be accepted
        in_port = 4'hE;
        idle(DEB - 1);
        in_port = 4'hF;
        idle(L + 2);
        rd(2'd0, 32'h0000000F, "glitch_data");
        rd(2'd3, 32'h0, "glitch_cap");

        // Press latency, capture and irq timing
        wr(2'd2, 32'h1);
        address = 2'd0;
        in_port = 4'hE;
        for (int i = 1; i <= L + 2; i++) begin
            sb.push_back('{"deb_latency", (i >= L + 1) ? 32'hE : 32'hF});
            step();
            pop_cmp();
            chk("irq_latency", {31'b0, irq}, {31'b0, (i >= L + 1)});
        end
        rd(2'd3, 32'h1, "press_cap");

        // Release produces no event; then clear races a fresh press
        in_port = 4'hF;
        idle(L + 2);
        rd(2'd0, 32'hF, "release_data");
        in_port = 4'hE;
        idle(L - 1);
        wr(2'd3, 32'h1);
        step();
        chk("setwins_irq", {31'b0, irq}, 32'h1);
        rd(2'd3, 32'h1, "setwins_cap");
        wr(2'd3, 32'h1);
        chk("w1c_irq_hold", {31'b0, irq}, 32'h1);
        step();
        chk("w1c_irq_clear", {31'b0, irq}, 32'h0);
        rd(2'd3, 32'h0, "w1c_cap");

        // Simultaneous presses on keys 1 and 3, then mask removal
        in_port = 4'hF;
        idle(L + 2);
        wr(2'd2, 32'h2);
        in_port = 4'h5;
        idle(L + 2);
        rd(2'd3, 32'hA, "multi_cap");
        chk("multi_irq", {31'b0, irq}, 32'h1);
        wr(2'd2, 32'h0);
        step();
        chk("unmask_irq", {31'b0, irq}, 32'h0);
        rd(2'd3, 32'hA, "unmask_cap");

        // Table-driven key/mask patterns
        for (int v = 0; v < 6; v++) begin
            in_port = 4'hF;
            idle(L + 2);
            wr(2'd3, 32'hF);
            wr(2'd2, {28'b0, vecs[v].mask});
            in_port = vecs[v].keys;
            idle(L + 3);
            rd(2'd0, {28'b0, vecs[v].keys}, "vec_data");
            rd(2'd3, {28'b0, vecs[v].exp_cap}, "vec_cap");
            rd(2'd2, {28'b0, vecs[v].mask}, "vec_mask");
            chk("vec_irq", {31'b0, irq}, {31'b0, vecs[v].exp_irq});
        end
        in_port = 4'hF;
        idle(L + 2);
        wr(2'd3, 32'hF);
        wr(2'd0, 32'h0);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd0, 32'hF, "ro_data");
        rd(2'd1, 32'h0, "ro_reserved");
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'hF, "mask_upper");

        // Reset in the middle of a key-2 debounce count
        in_port = 4'hB;
        idle(3);
        reset   = 1'b1;
        in_port = 4'hF;
        idle(2);
        reset = 1'b0;
        idle(L + 2);
        rd(2'd0, 32'hF, "midrst_data");
        rd(2'd3, 32'h0, "midrst_cap");
        chk("midrst_irq", {31'b0, irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
